// File: rtl/tmds_pkg.sv
// TMDS receive constants, FSM state type and symbol helpers.
// Shared by tmds_word_aligner and tmds_channel_decoder.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOK0 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOK1 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOK2 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOK3 = 10'b1010101011;

  localparam logic signed [5:0] DISP_LIMIT = 6'sd10;

  typedef enum logic {
    HUNT,
    LOCKED
  } tmds_state_t;

  function automatic logic [7:0] tmds_decode_data(
    input logic [9:0] w
  );
    logic [7:0] d;
    logic [7:0] q;
    d    = w[9] ? ~w[7:0] : w[7:0];
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = w[8] ? (d[i] ^ d[i-1])
                  : ~(d[i] ^ d[i-1]);
    end
    return q;
  endfunction

  // ones minus zeros of a 10-bit symbol
  function automatic logic signed [5:0] sym_disparity(
    input logic [9:0] w
  );
    logic signed [5:0] r;
    r = -6'sd10;
    for (int i = 0; i < 10; i++) begin
      if (w[i]) r = r + 6'sd2;
    end
    return r;
  endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// Symbol boundary search: barrel window over two words,
// control-token run detection and HUNT/LOCKED tracking.
module tmds_word_aligner
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN      = 16,
  parameter int SEARCH_WINDOW = 2048,
  parameter int LOSS_TIMEOUT  = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] raw_sym,
  output logic [9:0] win,
  output logic       is_ctrl,
  output logic [1:0] ctrl_code,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int RUN_W  = (CTRL_RUN > 1) ?
                          $clog2(CTRL_RUN) : 1;
  localparam int HUNT_W = $clog2(SEARCH_WINDOW);
  localparam int LOSS_W = $clog2(LOSS_TIMEOUT);

  localparam logic [RUN_W-1:0] RUN_LAST =
    RUN_W'(CTRL_RUN - 1);
  localparam logic [HUNT_W-1:0] HUNT_LAST =
    HUNT_W'(SEARCH_WINDOW - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST =
    LOSS_W'(LOSS_TIMEOUT - 1);

  tmds_state_t       state_q, state_d;
  logic [9:0]        prev_q;
  logic [9:0]        win_q;
  logic [19:0]       pair_sh;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [HUNT_W-1:0] hunt_q, hunt_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic [3:0]        off_q, off_d;

  assign pair_sh   = {raw_sym, prev_q} >> off_q;
  assign win       = win_q;
  assign locked    = (state_q == LOCKED);
  assign offset    = off_q;

  always_comb begin
    is_ctrl   = 1'b1;
    ctrl_code = 2'b00;
    unique case (1'b1)
      (win_q == CTRL_TOK0): ctrl_code = 2'b00;
      (win_q == CTRL_TOK1): ctrl_code = 2'b01;
      (win_q == CTRL_TOK2): ctrl_code = 2'b10;
      (win_q == CTRL_TOK3): ctrl_code = 2'b11;
      default:              is_ctrl   = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    hunt_d  = hunt_q;
    loss_d  = loss_q;
    off_d   = off_q;
    unique case (state_q)
      HUNT: begin
        hunt_d = hunt_q + HUNT_W'(1);
        run_d  = is_ctrl ? run_q + RUN_W'(1) : '0;
        // lock takes priority over an offset step
        if (is_ctrl && run_q == RUN_LAST) begin
          state_d = LOCKED;
          run_d   = '0;
          hunt_d  = '0;
          loss_d  = '0;
        end else if (hunt_q == HUNT_LAST) begin
          off_d  = (off_q == 4'd9) ? 4'd0 : off_q + 4'd1;
          run_d  = '0;
          hunt_d = '0;
        end
      end
      LOCKED: begin
        if (is_ctrl) begin
          loss_d = '0;
        end else if (loss_q == LOSS_LAST) begin
          state_d = HUNT;
          run_d   = '0;
          hunt_d  = '0;
          loss_d  = '0;
        end else begin
          loss_d = loss_q + LOSS_W'(1);
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HUNT;
      prev_q  <= '0;
      win_q   <= '0;
      run_q   <= '0;
      hunt_q  <= '0;
      loss_q  <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= raw_sym;
      win_q   <= pair_sh[9:0];
      run_q   <= run_d;
      hunt_q  <= hunt_d;
      loss_q  <= loss_d;
      off_q   <= off_d;
    end
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS channel receiver: alignment, TMDS data/control decode.
// Define TMDS_DISPARITY_CHECK_EN for running-disparity error checks.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN      = 16,
  parameter int SEARCH_WINDOW = 2048,
  parameter int LOSS_TIMEOUT  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  raw_sym,
  output logic [7:0]  data,
  output logic [1:0]  ctrl,
  output logic        de,
  output logic        locked,
  output logic [3:0]  offset,
  output logic        sym_err,
  output logic [15:0] err_count
);

  logic [9:0]  win;
  logic        is_ctrl;
  logic [1:0]  ctrl_code;
  logic        err_pulse;
  logic [7:0]  data_q;
  logic [1:0]  ctrl_q;
  logic        de_q;
  logic        sym_err_q;
  logic [15:0] err_q;

  tmds_word_aligner #(
    .CTRL_RUN      (CTRL_RUN),
    .SEARCH_WINDOW (SEARCH_WINDOW),
    .LOSS_TIMEOUT  (LOSS_TIMEOUT)
  ) u_aligner (
    .clk       (clk),
    .reset     (reset),
    .raw_sym   (raw_sym),
    .win       (win),
    .is_ctrl   (is_ctrl),
    .ctrl_code (ctrl_code),
    .locked    (locked),
    .offset    (offset)
  );

`ifdef TMDS_DISPARITY_CHECK_EN
  logic signed [5:0] rd_q;
  logic signed [5:0] rd_sum;

  always_comb begin
    rd_sum    = rd_q + sym_disparity(win);
    err_pulse = locked && !is_ctrl &&
                (rd_sum > DISP_LIMIT ||
                 rd_sum < -DISP_LIMIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q <= '0;
    end else if (!locked || is_ctrl || err_pulse) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_sum;
    end
  end
`else
  logic lock_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_d <= 1'b0;
    end else begin
      lock_d <= locked;
    end
  end

  assign err_pulse = lock_d & ~locked;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q    <= '0;
      ctrl_q    <= '0;
      de_q      <= 1'b0;
      sym_err_q <= 1'b0;
      err_q     <= '0;
    end else begin
      sym_err_q <= err_pulse;
      if (is_ctrl) begin
        ctrl_q <= ctrl_code;
        de_q   <= 1'b0;
      end else begin
        data_q <= tmds_decode_data(win);
        de_q   <= 1'b1;
      end
      if (sym_err_q && err_q != 16'hFFFF) begin
        err_q <= err_q + 16'd1;
      end
    end
  end

  assign data      = data_q;
  assign ctrl      = ctrl_q;
  assign de        = de_q;
  assign sym_err   = sym_err_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed-vector bench for tmds_channel_decoder.
// Expected values are hand-encoded TMDS symbols and timings.
module tb_tmds_channel_decoder;

  localparam logic [9:0] T0 = 10'b1101010100;
  localparam logic [9:0] T3 = 10'b1010101011;
`ifdef TMDS_DISPARITY_CHECK_EN
  localparam bit DISP = 1'b1;
`else
  localparam bit DISP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  raw_sym;
  logic [7:0]  data;
  logic [1:0]  ctrl;
  logic        de;
  logic        locked;
  logic [3:0]  offset;
  logic        sym_err;
  logic [15:0] err_count;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [9:0] last_sym = '0;

  tmds_channel_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .raw_sym   (raw_sym),
    .data      (data),
    .ctrl      (ctrl),
    .de        (de),
    .locked    (locked),
    .offset    (offset),
    .sym_err   (sym_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic send(input logic [9:0] w);
    raw_sym = w;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // serial stream whose symbols start sh bits into each word
  task automatic send_sym(input logic [9:0] s,
                          input int sh);
    logic [19:0] pair;
    pair = {s, last_sym} >> (10 - sh);
    last_sym = s;
    send(pair[9:0]);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    cyc = 0;
    last_sym = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_lock"}, locked, 0);
    check({tag, "_data"}, data, 0);
    check({tag, "_ctrl"}, ctrl, 0);
    check({tag, "_de"}, de, 0);
    check({tag, "_off"}, offset, 0);
    check({tag, "_serr"}, sym_err, 0);
    check({tag, "_ecnt"}, err_count, 0);
  endtask

  initial begin
    logic [9:0] dw [4];
    logic [7:0] dx [4];
    int lock_at, drop_at, pulses, nch;
    int ch [4];
    logic [3:0] last_off;
    int reach_at, wrap_at;

    reset   = 1'b0;
    raw_sym = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    reset = 1'b1;
    cyc = 0;

    // aligned stream
    lock_at = 0;
    for (int i = 1; i <= 200; i++) begin
      send(T0);
      if (lock_at == 0 && locked) lock_at = cyc;
    end
    check("lock_call", lock_at, 18);
    check("lock_off", offset, 0);
    check("tok_ctrl", ctrl, 0);
    check("tok_de", de, 0);

    dw = '{10'h100, 10'h133, 10'h0FF, 10'h39E};
    dx = '{8'h00, 8'h55, 8'hFF, 8'hA3};
    for (int i = 0; i < 6; i++) begin
      send(i < 4 ? dw[i] : T0);
      if (i >= 2) begin
        check($sformatf("dat%0d", i - 2), data, dx[i-2]);
        check($sformatf("de%0d", i - 2), de, 1);
      end
    end
    send(T0);
    check("hold_data", data, 8'hA3);
    check("back_de", de, 0);
    check("back_ctrl", ctrl, 0);

    // disparity: three +6 symbols
    repeat (4) send(T0);
    for (int i = 0; i < 5; i++) begin
      send(i < 3 ? 10'h3FC : T0);
      if (i == 2) check("dsp_data", data, 8'h05);
      if (i >= 2)
        check($sformatf("dsp_err%0d", i - 2), sym_err,
              (DISP && i == 3) ? 1 : 0);
    end
    repeat (2) send(T0);
    check("dsp_ecnt", err_count, DISP ? 1 : 0);

    // loss of lock
    drop_at = 0;
    pulses  = 0;
    cyc     = 0;
    for (int i = 1; i <= 4110; i++) begin
      send(10'h133);
      if (drop_at == 0 && !locked) drop_at = cyc;
      if (sym_err) pulses++;
    end
    check("loss_call", drop_at, 4098);
    check("loss_off", offset, 0);
    check("loss_puls", pulses, DISP ? 0 : 1);
    check("loss_ecnt", err_count, 1);

    // reset while locked
    repeat (30) send(T3);
    check("pre_lock", locked, 1);
    check("pre_ctrl", ctrl, 3);
    #2 reset = 1'b0;
    #1;
    check_zero("mid");
    @(posedge clk);
    #1;
    check("mid_hold", locked, 0);
    check("mid_hctl", ctrl, 0);
    reset = 1'b1;
    cyc = 0;
    lock_at = 0;
    for (int i = 1; i <= 30; i++) begin
      send(T0);
      if (lock_at == 0 && locked) lock_at = cyc;
    end
    check("relock", lock_at, 18);

    // stream misaligned by 3 bits
    pulse_reset();
    nch = 0;
    last_off = 4'd0;
    for (int k = 0; k < 12000 && !locked; k++) begin
      send_sym((k % 1650) < 1600 ? T3 : 10'h100, 3);
      if (offset != last_off) begin
        if (nch < 4) ch[nch] = cyc;
        nch++;
        last_off = offset;
      end
    end
    check("mis_nch", nch, 3);
    check("mis_c1", ch[0], 2048);
    check("mis_c2", ch[1], 4096);
    check("mis_c3", ch[2], 6144);
    check("mis_lock", locked, 1);
    check("mis_off", offset, 3);
    check("mis_ctrl", ctrl, 3);

    // offset wrap 9 -> 0
    pulse_reset();
    reach_at = 0;
    for (int k = 0; k < 20000 && offset != 4'd9; k++) begin
      send(10'h100);
      if (offset == 4'd9) reach_at = cyc;
    end
    check("wrap_at9", reach_at, 18432);
    wrap_at = 0;
    for (int k = 0; k < 2300 && !locked; k++) begin
      send(T0);
      if (wrap_at == 0 && offset == 4'd0) wrap_at = cyc;
    end
    check("wrap_step", wrap_at - reach_at, 2048);
    check("wrap_lock", locked, 1);
    check("wrap_off", offset, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
